condicionador_botoes: RTL and testbench



---
 rtl/geogenius_pkg.sv | 13 +
 rtl/sincroniza_debounce.sv | 57 +++++
 rtl/condicionador_botoes.sv | 91 +++++++++
 tb/tb_condicionador_botoes.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/geogenius_pkg.sv
// Shared constants and FSM state encoding for the player button conditioning path.
package geogenius_pkg;

    localparam int N_BOTOES_DEFAULT    = 8;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        PRESSIONADO = 2'd1,
        BLOQUEADO   = 2'd2
    } estado_t;

endpackage

// File: rtl/sincroniza_debounce.sv
// Two-flop synchronizer followed by a shared-counter debounce filter.
// The whole vector must hold unchanged for COUNT cycles before it is accepted.
module sincroniza_debounce #(
    parameter int WIDTH = 8,
    parameter int COUNT = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] estavel
);

    localparam logic [15:0] CNT_MAX = 16'(COUNT - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;

    // Any change of the synchronized vector restarts the count; clearing at the
    // terminal value means the counter never wraps.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (s2_q == cand_q && cand_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = cand_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbour.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            s1_q     <= entrada;
            s2_q     <= s1_q;
            cand_q   <= s2_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign estavel = stable_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Turns debounced player buttons into single-cycle play events with a one-hot code.
// Multi-button presses are rejected, and every press needs a full release before the next.
module condicionador_botoes
    import geogenius_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                jogada_valida,
    output logic                jogada_invalida,
    output logic [N_BOTOES-1:0] jogada,
    output logic [N_BOTOES-1:0] botoes_limpos,
    output logic [1:0]          db_estado
);

    localparam logic [N_BOTOES-1:0] UM = N_BOTOES'(1);

    logic [N_BOTOES-1:0] stable;
    logic                nenhum;
    logic                um_so;

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                valida_q, valida_d;
    logic                invalida_q, invalida_d;

    sincroniza_debounce #(
        .WIDTH (N_BOTOES),
        .COUNT (DEBOUNCE_CYCLES)
    ) u_sincroniza_debounce (
        .clock   (clock),
        .reset   (reset),
        .entrada (botoes),
        .estavel (stable)
    );

    assign nenhum = (stable == '0);
    assign um_so  = !nenhum && ((stable & (stable - UM)) == '0);

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        estado_d   = estado_q;
        jogada_d   = jogada_q;
        valida_d   = 1'b0;
        invalida_d = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (um_so && habilita) begin
                    jogada_d = stable;
                    valida_d = 1'b1;
                    estado_d = PRESSIONADO;
                end else if (um_so) begin
                    // Held while disabled: wait for release, never accept it late.
                    estado_d = BLOQUEADO;
                end else if (!nenhum) begin
                    invalida_d = 1'b1;
                    estado_d   = BLOQUEADO;
                end
            end
            PRESSIONADO, BLOQUEADO: begin
                if (nenhum) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            jogada_q   <= '0;
            valida_q   <= 1'b0;
            invalida_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            jogada_q   <= jogada_d;
            valida_q   <= valida_d;
            invalida_q <= invalida_d;
        end
    end

    assign jogada_valida   = valida_q;
    assign jogada_invalida = invalida_q;
    assign jogada          = jogada_q;
    assign botoes_limpos   = stable;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed scenarios plus randomized traffic checked against a press-level reference model.
module tb_condicionador_botoes;
    import geogenius_pkg::*;

    localparam int N = N_BOTOES_DEFAULT;
    localparam int D = DEBOUNCE_CYCLES_SIM;

    logic         clock    = 1'b0;
    logic         reset    = 1'b1;
    logic [N-1:0] botoes   = '0;
    logic         habilita = 1'b1;
    logic         jogada_valida;
    logic         jogada_invalida;
    logic [N-1:0] jogada;
    logic [N-1:0] botoes_limpos;
    logic [1:0]   db_estado;

    int n_vec = 0;
    int n_err = 0;

    condicionador_botoes #(
        .N_BOTOES        (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .jogada_valida   (jogada_valida),
        .jogada_invalida (jogada_invalida),
        .jogada          (jogada),
        .botoes_limpos   (botoes_limpos),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: a value is accepted once the synchronized input has shown it
    // on D+1 consecutive samples; a press is judged only when the buttons were
    // fully released beforehand (modo 0 = released, 1 = accepted, 2 = rejected).
    logic [N-1:0] m_s1, m_s2, m_last, m_stable, m_jogada;
    int           m_run;
    int           m_modo;
    logic         m_valida, m_invalida;

    task automatic model_step();
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_stable = '0; m_jogada = '0;
            m_run = 1; m_modo = 0; m_valida = 1'b0; m_invalida = 1'b0;
        end else begin
            m_valida   = 1'b0;
            m_invalida = 1'b0;
            if (m_stable == '0) begin
                m_modo = 0;
            end else if (m_modo == 0) begin
                if ($countones(m_stable) > 1) begin
                    m_invalida = 1'b1; m_modo = 2;
                end else if (habilita) begin
                    m_valida = 1'b1; m_jogada = m_stable; m_modo = 1;
                end else begin
                    m_modo = 2;
                end
            end
            if (m_s2 == m_last) begin
                if (m_run <= D) m_run++;
            end else begin
                m_run = 1;
            end
            m_last = m_s2;
            if (m_run >= D + 1) m_stable = m_last;
            m_s2 = m_s1;
            m_s1 = botoes;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        int np;
        reset = 1'b1; botoes = 8'hFF;
        tick(); tick();
        n_vec++; if (jogada_valida !== 1'b0 || jogada_invalida !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got %b%b expected 00", jogada_valida, jogada_invalida); end
        n_vec++; if (jogada !== 8'h00) begin n_err++; $display("FAIL reset_jogada: got %h expected 00", jogada); end
        n_vec++; if (botoes_limpos !== 8'h00) begin n_err++; $display("FAIL reset_limpos: got %h expected 00", botoes_limpos); end
        n_vec++; if (db_estado !== 2'd0) begin n_err++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        reset = 1'b0; botoes = 8'h00;
        np = 0;
        for (int i = 0; i < 10; i++) begin tick(); np += int'(jogada_valida) + int'(jogada_invalida); end
        n_vec++; if (np !== 0) begin n_err++; $display("FAIL reset_idle_pulses: got %0d expected 0", np); end
    endtask

    task automatic test_clean_press();
        int first, nv;
        first = -1; nv = 0;
        botoes = 8'h04;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (jogada_valida) begin nv++; if (first < 0) first = k; end
        end
        n_vec++; if (first !== D + 4) begin n_err++; $display("FAIL press_latency: got %0d expected %0d", first, D + 4); end
        n_vec++; if (nv !== 1) begin n_err++; $display("FAIL press_count: got %0d expected 1", nv); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        n_vec++; if (jogada !== 8'h04) begin n_err++; $display("FAIL press_jogada_held: got %h expected 04", jogada); end
        n_vec++; if (db_estado !== 2'd0) begin n_err++; $display("FAIL press_release_estado: got %0d expected 0", db_estado); end
    endtask

    task automatic test_bounce();
        int leaks, first, nv;
        leaks = 0; first = -1; nv = 0;
        for (int i = 0; i < 20; i++) begin
            botoes = ((i / 2) % 2 == 0) ? 8'h10 : 8'h00;
            tick();
            if (botoes_limpos !== 8'h00) leaks++;
        end
        n_vec++; if (leaks !== 0) begin n_err++; $display("FAIL bounce_leak: got %0d cycles expected 0", leaks); end
        botoes = 8'h10;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (jogada_valida) begin nv++; if (first < 0) first = k; end
        end
        n_vec++; if (first !== D + 4 || nv !== 1) begin n_err++; $display("FAIL bounce_pulse: got cycle %0d count %0d expected cycle %0d count 1", first, nv, D + 4); end
        n_vec++; if (jogada !== 8'h10) begin n_err++; $display("FAIL bounce_jogada: got %h expected 10", jogada); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_multi();
        int nv, ni;
        nv = 0; ni = 0;
        botoes = 8'h81;
        for (int i = 0; i < 20; i++) begin tick(); nv += int'(jogada_valida); ni += int'(jogada_invalida); end
        n_vec++; if (ni !== 1 || nv !== 0) begin n_err++; $display("FAIL multi_pulses: got inv %0d val %0d expected inv 1 val 0", ni, nv); end
        n_vec++; if (db_estado !== 2'd2) begin n_err++; $display("FAIL multi_estado: got %0d expected 2", db_estado); end
        n_vec++; if (jogada !== 8'h10) begin n_err++; $display("FAIL multi_jogada_kept: got %h expected 10", jogada); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        n_vec++; if (db_estado !== 2'd0) begin n_err++; $display("FAIL multi_release: got %0d expected 0", db_estado); end
        nv = 0;
        botoes = 8'h02;
        for (int i = 0; i < 20; i++) begin tick(); nv += int'(jogada_valida); end
        n_vec++; if (nv !== 1 || jogada !== 8'h02) begin n_err++; $display("FAIL multi_next_press: got count %0d jogada %h expected 1 and 02", nv, jogada); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_hold();
        int nv, np;
        nv = 0; np = 0;
        botoes = 8'h01;
        for (int i = 0; i < 100; i++) begin tick(); nv += int'(jogada_valida); end
        n_vec++; if (nv !== 1) begin n_err++; $display("FAIL hold_single: got %0d expected 1", nv); end
        botoes = 8'h03;
        for (int i = 0; i < 30; i++) begin tick(); np += int'(jogada_valida) + int'(jogada_invalida); end
        n_vec++; if (np !== 0) begin n_err++; $display("FAIL hold_added: got %0d expected 0", np); end
        n_vec++; if (db_estado !== 2'd1) begin n_err++; $display("FAIL hold_estado: got %0d expected 1", db_estado); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        nv = 0;
        botoes = 8'h01;
        for (int i = 0; i < 20; i++) begin tick(); nv += int'(jogada_valida); end
        n_vec++; if (nv !== 1) begin n_err++; $display("FAIL hold_repress: got %0d expected 1", nv); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_habilita_and_reset();
        int np;
        np = 0;
        habilita = 1'b0; botoes = 8'h20;
        for (int i = 0; i < 20; i++) begin tick(); np += int'(jogada_valida) + int'(jogada_invalida); end
        n_vec++; if (np !== 0 || db_estado !== 2'd2) begin n_err++; $display("FAIL disabled_press: got pulses %0d estado %0d expected 0 and 2", np, db_estado); end
        habilita = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); np += int'(jogada_valida) + int'(jogada_invalida); end
        n_vec++; if (np !== 0 || jogada !== 8'h01) begin n_err++; $display("FAIL enable_while_held: got pulses %0d jogada %h expected 0 and 01", np, jogada); end
        botoes = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        botoes = 8'h08;
        tick(); tick(); tick();
        reset = 1'b1; botoes = 8'h00;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); np += int'(jogada_valida) + int'(jogada_invalida); end
        n_vec++; if (np !== 0 || db_estado !== 2'd0 || jogada !== 8'h00) begin n_err++; $display("FAIL reset_mid_debounce: got pulses %0d estado %0d jogada %h expected 0 0 00", np, db_estado, jogada); end
    endtask

    task automatic test_random();
        logic [N-1:0] one;
        logic [N-1:0] v;
        int           seg;
        one = N'(1);
        seg = 0;
        v   = '0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                case ($urandom_range(0, 4))
                    0:       v = '0;
                    1, 2:    v = one << $urandom_range(0, N - 1);
                    3:       v = (one << $urandom_range(0, N - 1)) | (one << $urandom_range(0, N - 1));
                    default: v = N'($urandom);
                endcase
                seg      = int'($urandom_range(1, 12));
                habilita = ($urandom_range(0, 7) != 0);
            end
            seg--;
            botoes = v;
            reset  = ($urandom_range(0, 199) == 0);
            tick();
            n_vec++;
            if (jogada_valida !== m_valida || jogada_invalida !== m_invalida || jogada !== m_jogada ||
                botoes_limpos !== m_stable || db_estado !== 2'(m_modo)) begin
                n_err++;
                $display("FAIL random_cycle_%0d: got val %b inv %b jog %h limpos %h est %0d expected val %b inv %b jog %h limpos %h est %0d",
                         c, jogada_valida, jogada_invalida, jogada, botoes_limpos, db_estado,
                         m_valida, m_invalida, m_jogada, m_stable, m_modo);
            end
        end
        reset = 1'b0; habilita = 1'b1; botoes = '0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_hold();
        test_habilita_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
